ttest_mul_pipe: RTL and testbench

Parametrised, pipelined integer multiplier for the tTest datapath. Replaces the fixed combinational 23x23 unsigned multiplier wherever the scheduler needs registered timing, signed or mixed-sign operands, or stalls from a downstream consumer. Operands enter through a valid/ready port. Products leave NUM_STAGE cycles later through a valid/ready port. Each pipeline stage collapses bubbles independently.

---
 rtl/ttest_mul_pipe.sv | 123 ++++++++++++
 tb/tb_ttest_mul_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttest_mul_pipe.sv
// rtl/ttest_mul_pipe.sv - pipelined signed/unsigned/mixed integer multiplier with valid/ready stages
//
// Purpose: multiplies din0 by din1, where each operand is independently treated as
// two's complement or unsigned. The product is reduced mod 2^dout_WIDTH and
// delivered NUM_STAGE register stages later. Every stage has its own valid flag, so
// an empty stage refills even while the output is stalled.
//
// Ports:
//   clk         in   1           rising-edge clock
//   reset       in   1           asynchronous active-high reset
//   in_valid    in   1           operand beat present
//   in_ready    out  1           stage 1 can accept a beat this cycle
//   din0        in   din0_WIDTH  operand 0
//   din1        in   din1_WIDTH  operand 1
//   din0_signed in   1           din0 is two's complement when 1
//   din1_signed in   1           din1 is two's complement when 1
//   out_valid   out  1           dout holds a result
//   out_ready   in   1           consumer takes the result this cycle
//   dout        out  dout_WIDTH  product mod 2^dout_WIDTH

module ttest_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 23,
  parameter int din1_WIDTH = 23,
  parameter int dout_WIDTH = 46
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din0_signed,
  input  logic                  din1_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout
);

  // Each operand gains one extension bit, so the exact signed product needs
  // din0_WIDTH + din1_WIDTH + 2 bits.
  localparam int PW = din0_WIDTH + din1_WIDTH + 2;

  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_num_stage
    $error("ttest_mul_pipe: NUM_STAGE must be in 1..8");
  end
  if (dout_WIDTH < 1 || dout_WIDTH > din0_WIDTH + din1_WIDTH + 1) begin : g_bad_dout_width
    $error("ttest_mul_pipe: dout_WIDTH must be in 1..din0_WIDTH+din1_WIDTH+1");
  end
  if (ID < 0) begin : g_bad_id
    $error("ttest_mul_pipe: ID must be non-negative");
  end

  // Operand extension: the MSB is replicated only for a signed operand. Both sides
  // are widened to PW up front so the multiply is a plain PW x PW signed product.
  logic                 sx0, sx1;
  logic signed [PW-1:0] op0_x, op1_x, prod;
  logic                 unused_prod_hi;

  assign sx0   = din0_signed & din0[din0_WIDTH-1];
  assign sx1   = din1_signed & din1[din1_WIDTH-1];
  assign op0_x = {{(PW-din0_WIDTH){sx0}}, din0};
  assign op1_x = {{(PW-din1_WIDTH){sx1}}, din1};
  assign prod  = op0_x * op1_x;
  // Bits above dout_WIDTH are discarded by the mod 2^dout_WIDTH reduction.
  assign unused_prod_hi = ^prod[PW-1:dout_WIDTH];

  // Stages are numbered 1..NUM_STAGE. adv[0] is the input-port transfer and
  // adv[k] means stage k hands its beat on. room[k] means stage k can take a beat
  // this cycle; room[NUM_STAGE+1] is the consumer.
  logic [NUM_STAGE:1]   v_q, v_d;
  logic [NUM_STAGE:0]   adv;
  logic [NUM_STAGE+1:1] room;
  logic [dout_WIDTH-1:0] data_q [1:NUM_STAGE];
  logic [dout_WIDTH-1:0] data_d [1:NUM_STAGE];
  // chain[0] is the fresh product, chain[k] the payload of stage k.
  logic [dout_WIDTH-1:0] chain  [0:NUM_STAGE];

  always_comb begin
    chain[0] = prod[dout_WIDTH-1:0];
    for (int k = 1; k <= NUM_STAGE; k++) begin
      chain[k] = data_q[k];
    end

    // Resolve readiness from the output backwards; this is the intended
    // combinational out_ready -> in_ready path.
    room = '0;
    adv  = '0;
    room[NUM_STAGE+1] = out_ready;
    for (int k = NUM_STAGE; k >= 1; k--) begin
      adv[k]  = v_q[k] & room[k+1];
      room[k] = ~v_q[k] | adv[k];
    end

    // While reset is held, stage 1 refuses input, although its flag is already clear.
    in_ready = ~reset & room[1];
    adv[0]   = in_valid & in_ready;

    for (int k = 1; k <= NUM_STAGE; k++) begin
      v_d[k]    = adv[k-1] | (v_q[k] & ~adv[k]);
      data_d[k] = adv[k-1] ? chain[k-1] : data_q[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 1; k <= NUM_STAGE; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 1; k <= NUM_STAGE; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = v_q[NUM_STAGE];
  assign dout      = data_q[NUM_STAGE];

endmodule

// File: tb/tb_ttest_mul_pipe.sv
// tb/tb_ttest_mul_pipe.sv - directed bench for ttest_mul_pipe (default, 1-stage/8-bit, 47-bit variants)

module tb_ttest_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [22:0] din0;
  logic [22:0] din1;
  logic        din0_signed;
  logic        din1_signed;

  logic        rdy_m, ov_m;
  logic [45:0] dout_m;
  logic        rdy_1, ov_1;
  logic [7:0]  dout_1;
  logic        rdy_w, ov_w;
  logic [46:0] dout_w;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ttest_mul_pipe #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(23), .din1_WIDTH(23), .dout_WIDTH(46)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m),
    .din0(din0), .din1(din1), .din0_signed(din0_signed), .din1_signed(din1_signed),
    .out_valid(ov_m), .out_ready(out_ready), .dout(dout_m)
  );

  ttest_mul_pipe #(.ID(2), .NUM_STAGE(1), .din0_WIDTH(23), .din1_WIDTH(23), .dout_WIDTH(8)) u_n1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_1),
    .din0(din0), .din1(din1), .din0_signed(din0_signed), .din1_signed(din1_signed),
    .out_valid(ov_1), .out_ready(out_ready), .dout(dout_1)
  );

  ttest_mul_pipe #(.ID(3), .NUM_STAGE(3), .din0_WIDTH(23), .din1_WIDTH(23), .dout_WIDTH(47)) u_w47 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w),
    .din0(din0), .din1(din1), .din0_signed(din0_signed), .din1_signed(din1_signed),
    .out_valid(ov_w), .out_ready(out_ready), .dout(dout_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    din0 = '0;
    din1 = '0;
    din0_signed = 1'b0;
    din1_signed = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    din0 = 23'h7FFFFF;
    din1 = 23'h7FFFFF;
    din0_signed = 1'b0;
    din1_signed = 1'b0;
    #3;
    n_checks++;
    if (ov_m !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", ov_m);
    else n_pass++;
    n_checks++;
    if (dout_m !== 46'h0) $display("FAIL reset_dout: got %h want 0", dout_m);
    else n_pass++;
    n_checks++;
    if (rdy_m !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", rdy_m);
    else n_pass++;
    n_checks++;
    if ({ov_1, dout_1} !== 9'h0) $display("FAIL reset_n1_out: got %b/%h want 0/00", ov_1, dout_1);
    else n_pass++;
    do_reset();
    #1;
    n_checks++;
    if (rdy_m !== 1'b1) $display("FAIL post_reset_in_ready: got %0b want 1", rdy_m);
    else n_pass++;
  endtask

  task automatic test_unsigned();
    int lat;
    do_reset();
    out_ready = 1'b1;
    din0 = 23'h7FFFFF;
    din1 = 23'h7FFFFF;
    in_valid = 1'b1;
    #1;
    n_checks++;
    if (rdy_m !== 1'b1) $display("FAIL unsigned_in_ready: got %0b want 1", rdy_m);
    else n_pass++;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (ov_m !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat != 3) $display("FAIL unsigned_latency: got %0d edges want 3", lat);
    else n_pass++;
    n_checks++;
    if (dout_m !== 46'h3FFFFF000001) $display("FAIL unsigned_dout: got %h want 3fffff000001", dout_m);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [22:0] a  [3];
    logic [22:0] b  [3];
    logic        sa [3];
    logic        sb [3];
    logic [45:0] ex [3];
    a[0] = 23'h7FFFFF; b[0] = 23'h000003; sa[0] = 1'b1; sb[0] = 1'b1; ex[0] = 46'h3FFFFFFFFFFD;
    a[1] = 23'h7FFFFF; b[1] = 23'h7FFFFF; sa[1] = 1'b1; sb[1] = 1'b0; ex[1] = 46'h3FFFFF800001;
    a[2] = 23'h400000; b[2] = 23'h400000; sa[2] = 1'b1; sb[2] = 1'b1; ex[2] = 46'h100000000000;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din0 = a[i];
      din1 = b[i];
      din0_signed = sa[i];
      din1_signed = sb[i];
      in_valid = 1'b1;
      #1;
      n_checks++;
      if (rdy_m !== 1'b1) $display("FAIL b2b_in_ready_%0d: got %0b want 1", i, rdy_m);
      else n_pass++;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({ov_m, dout_m} !== {1'b1, ex[i]})
        $display("FAIL b2b_result_%0d: got v=%0b %h want v=1 %h", i, ov_m, dout_m, ex[i]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_backpressure();
    int          sent = 0;
    int          recv = 0;
    int          stall = 0;
    int          held_at = -1;
    bit          seen = 1'b0;
    bit          stable = 1'b1;
    bit          ov_held = 1'b1;
    logic [45:0] stall_dout = '0;
    logic [45:0] exp_p;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      if (ov_m === 1'b1) seen = 1'b1;
      if (seen && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (sent < 8) begin
        in_valid = 1'b1;
        din0 = 23'(sent + 1);
        din1 = 23'(sent + 2);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_ready == 1'b0) begin
        if (stall == 1) stall_dout = dout_m;
        else if (dout_m !== stall_dout) stable = 1'b0;
        if (ov_m !== 1'b1) ov_held = 1'b0;
      end
      if (in_valid && rdy_m !== 1'b1 && held_at < 0) held_at = sent - recv;
      if (in_valid && rdy_m === 1'b1) sent++;
      if (ov_m === 1'b1 && out_ready) begin
        exp_p = 46'((recv + 1) * (recv + 2));
        n_checks++;
        if (dout_m !== exp_p) $display("FAIL bp_result_%0d: got %h want %h", recv, dout_m, exp_p);
        else n_pass++;
        recv++;
      end
      step();
    end
    n_checks++;
    if (held_at != 3) $display("FAIL bp_in_ready_drop: dropped with %0d held want 3", held_at);
    else n_pass++;
    n_checks++;
    if (stable !== 1'b1 || ov_held !== 1'b1)
      $display("FAIL bp_stall_stable: dout_stable=%0b valid_held=%0b want 1/1", stable, ov_held);
    else n_pass++;
    n_checks++;
    if (recv != 8) $display("FAIL bp_count: got %0d results want 8", recv);
    else n_pass++;
    n_checks++;
    if (ov_m !== 1'b0) $display("FAIL bp_drained: out_valid=%0b want 0", ov_m);
    else n_pass++;
  endtask

  task automatic test_bubble();
    bit rdy_ok = 1'b1;
    do_reset();
    out_ready = 1'b0;
    din0 = 23'd5;
    din1 = 23'd7;
    in_valid = 1'b1;
    #1;
    if (rdy_m !== 1'b1) rdy_ok = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (2) begin
      #1;
      if (rdy_m !== 1'b1) rdy_ok = 1'b0;
      step();
    end
    din0 = 23'd9;
    din1 = 23'd11;
    in_valid = 1'b1;
    #1;
    if (rdy_m !== 1'b1) rdy_ok = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
    if (rdy_m !== 1'b1) rdy_ok = 1'b0;
    step();
    #1;
    if (rdy_m !== 1'b1) rdy_ok = 1'b0;
    n_checks++;
    if (rdy_ok !== 1'b1) $display("FAIL bubble_in_ready: in_ready dropped, want 1 throughout");
    else n_pass++;
    n_checks++;
    if ({ov_m, dout_m} !== {1'b1, 46'd35}) $display("FAIL bubble_head: got v=%0b %h want v=1 %h", ov_m, dout_m, 46'd35);
    else n_pass++;
    out_ready = 1'b1;
    step();
    n_checks++;
    if ({ov_m, dout_m} !== {1'b1, 46'd99}) $display("FAIL bubble_second: got v=%0b %h want v=1 %h", ov_m, dout_m, 46'd99);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit stale = 1'b0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din0 = 23'(i + 1);
      din1 = 23'(i + 4);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (ov_m !== 1'b1) $display("FAIL rmid_full: out_valid=%0b want 1", ov_m);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({ov_m, rdy_m} !== 2'b00) $display("FAIL rmid_flags: got v=%0b rdy=%0b want 0/0", ov_m, rdy_m);
    else n_pass++;
    n_checks++;
    if (dout_m !== 46'h0) $display("FAIL rmid_dout: got %h want 0", dout_m);
    else n_pass++;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (rdy_m !== 1'b1) $display("FAIL rmid_release_ready: got %0b want 1", rdy_m);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      if (ov_m !== 1'b0) stale = 1'b1;
      step();
    end
    n_checks++;
    if (stale !== 1'b0) $display("FAIL rmid_stale: stale beat emitted after reset, want none");
    else n_pass++;
  endtask

  task automatic test_widths();
    do_reset();
    out_ready = 1'b1;
    din0 = 23'h0000FF;
    din1 = 23'h0000FF;
    in_valid = 1'b1;
    #1;
    step();
    n_checks++;
    if ({ov_1, dout_1} !== {1'b1, 8'h01}) $display("FAIL n1_ff_sq: got v=%0b %h want v=1 01", ov_1, dout_1);
    else n_pass++;
    din0 = 23'h7FFFFF;
    din1 = 23'h000001;
    din0_signed = 1'b1;
    din1_signed = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({ov_1, dout_1} !== {1'b1, 8'hFF}) $display("FAIL n1_neg: got v=%0b %h want v=1 ff", ov_1, dout_1);
    else n_pass++;
    step();
    n_checks++;
    if (ov_1 !== 1'b0) $display("FAIL n1_drained: out_valid=%0b want 0", ov_1);
    else n_pass++;
    n_checks++;
    if ({ov_w, dout_w} !== {1'b1, 47'h00000000FE01}) $display("FAIL w47_first: got v=%0b %h want v=1 fe01", ov_w, dout_w);
    else n_pass++;
    step();
    n_checks++;
    if ({ov_w, dout_w} !== {1'b1, 47'h7FFFFFFFFFFF}) $display("FAIL w47_neg: got v=%0b %h want v=1 7fffffffffff", ov_w, dout_w);
    else n_pass++;
    n_checks++;
    if ({ov_m, dout_m} !== {1'b1, 46'h3FFFFFFFFFFF}) $display("FAIL w46_neg: got v=%0b %h want v=1 3fffffffffff", ov_m, dout_m);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unsigned();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    test_widths();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
